mc_sequencer: RTL
=================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, is the number of consecutive stalled memory cycles before mem_timeout is set.
REQ-002 clk  in  1  clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 op  in  6  opcode field from the instruction register.
REQ-005 funct  in  6  function field from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  unified memory has completed the current access.
REQ-008 iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen  out  1 each  datapath controls.
REQ-009 alusrcb  out  2  ALU B select: 00=reg, 01=const 4, 10=signimm, 11=signimm<<2.
REQ-010 pcsrc  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 state_o  out  4  current state encoding, for debug.
REQ-013 illegal_op  out  1  one-cycle pulse on an undecodable instruction.
REQ-014 mem_timeout  out  1  sticky memory-stall error flag.

Function
REQ-015 Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-016 FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00; irwrite=pcen=mem_ready; the FSM advances to DECODE only when mem_ready=1.
REQ-017 DECODE (alusrca=0, alusrcb=11, add) branches on the opcode: lw/sw to MEMADR, R-type to EXEC, beq to BRANCH, addi to ADDIEX, j to JUMP.
REQ-018 MEMADR: alusrca=1, alusrcb=10, add; the next state is MEMRD for lw and MEMWR for sw.
REQ-019 MEMRD: iord=1; the FSM holds until mem_ready=1, then goes to MEMWB.
REQ-020 MEMWB: regdst=0, memtoreg=1, regwrite=1; the next state is FETCH.
REQ-021 MEMWR: iord=1, memwrite=1 held for every cycle in the state; the FSM goes to FETCH on the cycle mem_ready=1.
REQ-022 EXEC: alusrca=1, alusrcb=00, alucontrol from funct, then ALUWB; ALUWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
REQ-023 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero (combinational), then FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, add, then ADDIWB; ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
REQ-025 JUMP: pcsrc=10, pcen=1, then FETCH.
REQ-026 Any enable not listed for a state (irwrite, memwrite, regwrite, pcen) shall be 0 in that state; unlisted selects shall be 0.
REQ-027 An unknown opcode, or R-type with an unsupported funct, in DECODE shall pulse illegal_op for one cycle and return to FETCH with no register or memory write.
REQ-028 A stall counter shall count consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready=0, saturate, and clear on mem_ready=1 or a state change.
REQ-029 When the stall count reaches MEM_TIMEOUT, mem_timeout shall set and hold until reset; sequencing continues unchanged.
REQ-030 Latencies with mem_ready=1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-031 While reset=1, state=FETCH, the stall counter=0, mem_timeout=0, illegal_op=0, and irwrite, pcen, regwrite and memwrite are forced to 0.
REQ-032 Reset asserted mid-instruction shall drop all write enables in the same cycle, asynchronously.

Configuration
REQ-033 With macro MC_SEQUENCER_JUMP_EN defined, op 000010 shall decode to JUMP.
REQ-034 Without MC_SEQUENCER_JUMP_EN, the JUMP state shall be absent and op 000010 shall be treated as illegal (REQ-027).

Structure
REQ-035 Package mc_pkg shall hold the state encodings, opcode and funct constants, and the alusrcb and pcsrc codes.
REQ-036 Sub-module mc_ctrl_rom shall provide the combinational state-to-control-word decode; the FSM, stall counter and flags shall stay in mc_sequencer.

Verification
REQ-037 lw (op 100011), mem_ready=1: states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-038 sw (op 101011), mem_ready low for 3 cycles in MEMWR: memwrite=1 for 4 cycles, then state 0.
REQ-039 beq with zero=1 gives pcen=1 in BRANCH; beq with zero=0 gives pcen=0; both return to FETCH after 3 cycles.
REQ-040 op 111111: illegal_op pulses once after DECODE and the next state is 0; with the macro undefined, op 000010 gives the same response.
REQ-041 MEM_TIMEOUT=4 with mem_ready held 0 in FETCH: mem_timeout rises after the 4th stalled cycle and stays 1 after mem_ready returns.
REQ-042 reset asserted while in MEMWR: memwrite=0 immediately, state_o=0, and FETCH resumes after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle sequencer: state encodings, opcode
// and funct constants, datapath select codes and the control-word layout.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU B operand select
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       pcen;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
               (f == FUNCT_OR)  || (f == FUNCT_SLT);
    endfunction

    function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
        logic [2:0] a;
        a = ALU_ADD;
        case (f)
            FUNCT_SUB: a = ALU_SUB;
            FUNCT_AND: a = ALU_AND;
            FUNCT_OR:  a = ALU_OR;
            FUNCT_SLT: a = ALU_SLT;
            default:   a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational state-to-control-word decode. The only input-dependent
// entries are the FETCH enables (mem_ready), the BRANCH pcen (zero) and
// the EXEC ALU op (funct). JUMP exists only with MC_SEQUENCER_JUMP_EN.
module mc_ctrl_rom
    import mc_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    // Everything defaults to 0; each state raises only what it needs
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb    = ALUB_FOUR;
                ctrl.alucontrol = ALU_ADD;
                ctrl.pcsrc      = PCSRC_ALU;
                ctrl.irwrite    = mem_ready;
                ctrl.pcen       = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb    = ALUB_IMM_SH;
                ctrl.alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = ALUB_IMM;
                ctrl.alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = ALUB_REG;
                ctrl.alucontrol = funct_to_alu(funct);
            end
            S_ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = ALUB_REG;
                ctrl.alucontrol = ALU_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcen       = zero;
            end
            S_ADDIEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = ALUB_IMM;
                ctrl.alucontrol = ALU_ADD;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
`ifdef MC_SEQUENCER_JUMP_EN
            S_JUMP: begin
                ctrl.pcsrc = PCSRC_JUMP;
                ctrl.pcen  = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle MIPS control sequencer: state register, next-state logic,
// memory stall watchdog and illegal-instruction flag. Control words come
// from mc_ctrl_rom. Define MC_SEQUENCER_JUMP_EN to decode j (op 000010);
// otherwise it is treated as illegal.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state_o,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int                CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = CNT_W'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               timeout_q, timeout_d;
    logic               illegal_q, illegal_d;
    logic               mem_wait;
    ctrl_t              ctrl;

    mc_ctrl_rom u_rom (
        .state     (state_q),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Next state plus illegal-instruction detection in DECODE
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
`ifdef MC_SEQUENCER_JUMP_EN
                    OP_J:    state_d = S_JUMP;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`ifdef MC_SEQUENCER_JUMP_EN
            S_JUMP:   state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Saturating count of consecutive stalled memory cycles; any ready
    // cycle or state change restarts it. The timeout flag is sticky.
    always_comb begin
        mem_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        stall_d  = '0;
        if (mem_wait && !mem_ready && (state_d == state_q))
            stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
        timeout_d = timeout_q || (stall_d == STALL_MAX);
    end

    // State and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            stall_q   <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    // Write enables are gated by reset so they drop in the same cycle,
    // independent of what FETCH would otherwise drive from mem_ready.
    assign iord        = ctrl.iord;
    assign irwrite     = ctrl.irwrite  && !reset;
    assign memwrite    = ctrl.memwrite && !reset;
    assign regwrite    = ctrl.regwrite && !reset;
    assign pcen        = ctrl.pcen     && !reset;
    assign regdst      = ctrl.regdst;
    assign memtoreg    = ctrl.memtoreg;
    assign alusrca     = ctrl.alusrca;
    assign alusrcb     = ctrl.alusrcb;
    assign pcsrc       = ctrl.pcsrc;
    assign alucontrol  = ctrl.alucontrol;
    assign state_o     = state_q;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;

endmodule
